// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the multiplexed seven-segment display driver:
// scan FSM state encoding, the hex-to-segment lookup table and the
// all-segments-off constant.
// Segment bit order everywhere is {g,f,e,d,c,b,a}, active-high.
// ---------------------------------------------------------------------------
package display_pkg;

    // Scan FSM: dead-time blanking slot followed by the lit portion of a slot
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Segment pattern that lights nothing
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Hex digit patterns, index 15 on the left, index 0 on the right.
    // 'b' and 'd' are drawn lowercase so they cannot be confused with 8 and 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    // Table lookup wrapped as a function so callers do not index the constant
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Purely combinational nibble to seven-segment decoder, full hex 0-F,
// driven from the shared table in display_pkg.
// ---------------------------------------------------------------------------
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; no state, no registered output here
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
// Multiplexed seven-segment display driver. Latches 4-bit digit values and
// decimal points, then walks a one-hot digit-enable ring. Every digit slot is
// SCAN_COUNT cycles long and starts with BLANK_CYCLES of dead time in which
// everything is dark, to avoid ghosting between neighbouring digits.
//
// New values from 'load' are held in a pending buffer and only copied into
// the displayed (active) buffer when the ring wraps back to digit 0, so one
// frame never mixes old and new digits.
//
// Optional feature macro: DISPLAY_BLINK_EN
//   defined   -> adds the blink_mask port and a free-running blink phase
//                counter; masked digits go dark during the "off" phase.
//   undefined -> no blink_mask port, no counter; nothing blinks.
//
// All outputs are registered and are computed from the next-state values so
// they line up exactly with the FSM state of the same cycle.
// ---------------------------------------------------------------------------
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_COUNT   = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_COUNT  = 25000000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lz_en,
`ifdef DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic [6:0]                segments,
    output logic                      dp,
    output logic                      scan_tick
);

    localparam int CNT_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIG_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_COUNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Reject parameter sets the timing scheme cannot honour
    if (NUM_DIGITS < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_COUNT ||
        BLINK_COUNT < 1) begin : g_param_check
        $error("display_scan_ctrl: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // State and buffers
    // ------------------------------------------------------------------
    scan_state_t             state_reg,        state_next;
    logic [CNT_W-1:0]        cnt_reg,          cnt_next;
    logic [IDX_W-1:0]        idx_reg,          idx_next;
    logic [DIG_W-1:0]        act_digits_reg,   act_digits_next;
    logic [NUM_DIGITS-1:0]   act_dp_reg,       act_dp_next;
    logic [DIG_W-1:0]        pend_digits_reg,  pend_digits_next;
    logic [NUM_DIGITS-1:0]   pend_dp_reg,      pend_dp_next;
    logic                    pend_flag_reg,    pend_flag_next;

    logic [NUM_DIGITS-1:0]   digit_en_reg,     digit_en_next;
    logic [6:0]              segments_reg,     segments_next;
    logic                    dp_reg,           dp_next;
    logic                    scan_tick_reg,    scan_tick_next;

    logic                    slot_end;
    logic                    frame_end;
    logic                    show_next;

    logic [3:0]              nib_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              nib_sel;
    logic [6:0]              dec_seg;
    logic                    suppress;
    logic                    blink_off;

    // ------------------------------------------------------------------
    // Scan sequencing and update buffering (next-state)
    // ------------------------------------------------------------------
    assign slot_end  = (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    // Slot counter, FSM transitions, digit ring and pending/active buffers
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg + CNT_W'(1);
        idx_next         = idx_reg;
        scan_tick_next   = 1'b0;
        act_digits_next  = act_digits_reg;
        act_dp_next      = act_dp_reg;
        pend_digits_next = pend_digits_reg;
        pend_dp_next     = pend_dp_reg;
        pend_flag_next   = pend_flag_reg;

        if (slot_end) begin
            // Next slot always opens with dead time
            cnt_next       = '0;
            state_next     = ST_BLANK;
            scan_tick_next = 1'b1;
            idx_next       = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end else if (state_reg == ST_BLANK && cnt_reg == BLANK_LAST) begin
            state_next = ST_SHOW;
        end

        if (frame_end) begin
            // Frame boundary: a load on this very cycle bypasses the pending
            // buffer; otherwise a waiting update is promoted. Either way the
            // pending buffer is now consumed.
            if (load) begin
                act_digits_next = digits_in;
                act_dp_next     = dp_in;
            end else if (pend_flag_reg) begin
                act_digits_next = pend_digits_reg;
                act_dp_next     = pend_dp_reg;
            end
            pend_flag_next = 1'b0;
        end else if (load) begin
            // Mid-frame loads overwrite each other; the last one wins
            pend_digits_next = digits_in;
            pend_dp_next     = dp_in;
            pend_flag_next   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection, leading-zero suppression and decode
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nib_arr[gi] = act_digits_next[4*gi +: 4];

        // A digit is a leading zero when it and every digit to its left are 0;
        // the rightmost digit always stays visible so zero still reads "0".
        if (gi == 0) begin : g_lz_first
            assign lz_mask[gi] = 1'b0;
        end else begin : g_lz_rest
            assign lz_mask[gi] = (act_digits_next[DIG_W-1:4*gi] == '0);
        end

        // One-hot enable ring, dark during the blanking part of the slot
        assign digit_en_next[gi] = show_next && (idx_next == IDX_W'(gi));
    end

    assign show_next = (state_next == ST_SHOW);
    assign nib_sel   = nib_arr[idx_next];
    assign suppress  = lz_en && lz_mask[idx_next];

    seg7_decoder u_seg7_decoder (
        .nibble (nib_sel),
        .seg    (dec_seg)
    );

`ifdef DISPLAY_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_COUNT + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_COUNT - 1);

    logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic               blink_on_reg,  blink_on_next;

    // Blink phase flips every BLINK_COUNT cycles, free-running from reset
    always_comb begin
        blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
        blink_on_next  = blink_on_reg;
        if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            blink_on_next  = ~blink_on_reg;
        end
    end

    // Blink counter and phase registers; phase starts in "on"
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            blink_on_reg  <= blink_on_next;
        end
    end

    assign blink_off = !blink_on_next && blink_mask[idx_next];
`else
    assign blink_off = 1'b0;
`endif

    // Segment and decimal-point values for the upcoming cycle
    always_comb begin
        segments_next = SEG_OFF;
        dp_next       = 1'b0;
        if (show_next && !blink_off) begin
            // Suppression darkens the digit body only; its point stays live
            segments_next = suppress ? SEG_OFF : dec_seg;
            dp_next       = act_dp_next[idx_next];
        end
    end

    // ------------------------------------------------------------------
    // Registers: FSM state, buffers and all outputs
    // ------------------------------------------------------------------
    // Single sequential block for the scan FSM and its registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= ST_BLANK;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            act_digits_reg  <= '0;
            act_dp_reg      <= '0;
            pend_digits_reg <= '0;
            pend_dp_reg     <= '0;
            pend_flag_reg   <= 1'b0;
            digit_en_reg    <= '0;
            segments_reg    <= SEG_OFF;
            dp_reg          <= 1'b0;
            scan_tick_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            act_digits_reg  <= act_digits_next;
            act_dp_reg      <= act_dp_next;
            pend_digits_reg <= pend_digits_next;
            pend_dp_reg     <= pend_dp_next;
            pend_flag_reg   <= pend_flag_next;
            digit_en_reg    <= digit_en_next;
            segments_reg    <= segments_next;
            dp_reg          <= dp_next;
            scan_tick_reg   <= scan_tick_next;
        end
    end

    assign digit_en  = digit_en_reg;
    assign segments  = segments_reg;
    assign dp        = dp_reg;
    assign scan_tick = scan_tick_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
// Directed bench for display_scan_ctrl with NUM_DIGITS=4, SCAN_COUNT=8,
// BLANK_CYCLES=2 (slot = 8 cycles, frame = 32 cycles). Inputs change and
// outputs are sampled on the falling clock edge. Comments "t=N" give the
// number of rising edges since the last reset release, so within a frame
// idx = (N/8)%4 and the slot counter = N%8.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int ND = 4;

    logic            clk;
    logic            rstn;
    logic            load;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0]   dp_in;
    logic            lz_en;
`ifdef DISPLAY_BLINK_EN
    logic [ND-1:0]   blink_mask;
`endif
    logic [ND-1:0]   digit_en;
    logic [6:0]      segments;
    logic            dp;
    logic            scan_tick;

    int n_cmp = 0;
    int n_mis = 0;

    display_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_COUNT   (8),
        .BLANK_CYCLES (2),
        .BLINK_COUNT  (64)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
`ifdef DISPLAY_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .digit_en   (digit_en),
        .segments   (segments),
        .dp         (dp),
        .scan_tick  (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
        $display("check %-12s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        load      = 1'b1;
        digits_in = d;
        dp_in     = p;
        tick(1);
        load      = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        lz_en     = 1'b0;
`ifdef DISPLAY_BLINK_EN
        blink_mask = '0;
`endif
        tick(3);
        check("rst_en",   32'(digit_en),  32'h0);
        check("rst_seg",  32'(segments),  32'h0);
        check("rst_dp",   32'(dp),        32'h0);
        check("rst_tick", 32'(scan_tick), 32'h0);

        // ---- power-up scan: 2 blank, 6 lit, tick, next digit ----
        rstn = 1'b1;                                   // t=0
        check("t0_en",    32'(digit_en), 32'h0);
        tick(1);                                       // t=1
        check("t1_en",    32'(digit_en), 32'h0);
        tick(1);                                       // t=2
        check("t2_en",    32'(digit_en), 32'h1);
        check("t2_seg",   32'(segments), 32'h3F);
        tick(5);                                       // t=7
        check("t7_en",    32'(digit_en),  32'h1);
        check("t7_tick",  32'(scan_tick), 32'h0);
        tick(1);                                       // t=8
        check("t8_tick",  32'(scan_tick), 32'h1);
        check("t8_en",    32'(digit_en),  32'h0);
        tick(2);                                       // t=10
        check("t10_en",   32'(digit_en),  32'h2);
        check("t10_tick", 32'(scan_tick), 32'h0);

        // ---- load 1234 mid frame 0, shown from frame 1 ----
        do_load(16'h1234, 4'b0100);                    // t=11
        tick(15);                                      // t=26 idx3 frame0
        check("f0_hold",  32'(segments), 32'h3F);
        tick(8);                                       // t=34 idx0 frame1
        check("f1_en0",   32'(digit_en), 32'h1);
        check("f1_seg0",  32'(segments), 32'h66);
        check("f1_dp0",   32'(dp),       32'h0);
        tick(8);                                       // t=42
        check("f1_seg1",  32'(segments), 32'h4F);
        tick(8);                                       // t=50
        check("f1_en2",   32'(digit_en), 32'h4);
        check("f1_seg2",  32'(segments), 32'h5B);
        check("f1_dp2",   32'(dp),       32'h1);
        tick(8);                                       // t=58
        check("f1_seg3",  32'(segments), 32'h06);

        // ---- leading-zero suppression on 0070 ----
        lz_en = 1'b1;
        do_load(16'h0070, 4'b0100);                    // t=59
        tick(7);                                       // t=66 frame2 idx0
        check("lz_seg0",  32'(segments), 32'h3F);
        tick(8);                                       // t=74
        check("lz_seg1",  32'(segments), 32'h07);
        tick(8);                                       // t=82
        check("lz_en2",   32'(digit_en), 32'h4);
        check("lz_seg2",  32'(segments), 32'h0);
        check("lz_dp2",   32'(dp),       32'h1);
        tick(8);                                       // t=90
        check("lz_seg3",  32'(segments), 32'h0);
        lz_en = 1'b0;
        tick(1);                                       // t=91
        check("nolz_seg3", 32'(segments), 32'h3F);
        tick(23);                                      // t=114 frame3 idx2
        check("nolz_seg2", 32'(segments), 32'h3F);

        // ---- AAAA then 000B within frame 3: last wins ----
        do_load(16'hAAAA, 4'b0000);                    // t=115
        tick(7);                                       // t=122 idx3
        check("aa_hold",  32'(segments), 32'h3F);
        do_load(16'h000B, 4'b0000);                    // t=123
        tick(7);                                       // t=130 frame4 idx0
        check("b_seg0",   32'(segments), 32'h7C);
        tick(8);                                       // t=138
        check("b_seg1",   32'(segments), 32'h3F);
        tick(8);                                       // t=146
        check("b_seg2",   32'(segments), 32'h3F);

        // ---- pending 9999, then load 5678 on the frame boundary ----
        tick(4);                                       // t=150
        do_load(16'h9999, 4'b0000);                    // t=151
        tick(3);                                       // t=154
        check("b_seg3",   32'(segments), 32'h3F);
        tick(5);                                       // t=159 last cycle of frame4
        do_load(16'h5678, 4'b0000);                    // t=160
        check("fb_tick",  32'(scan_tick), 32'h1);
        check("fb_en",    32'(digit_en),  32'h0);
        tick(2);                                       // t=162 frame5 idx0
        check("fb_seg0",  32'(segments), 32'h7F);
        tick(8);                                       // t=170
        check("fb_seg1",  32'(segments), 32'h07);
        tick(24);                                      // t=194 frame6 idx0
        check("fb_f6seg0", 32'(segments), 32'h7F);

        // ---- asynchronous reset in the middle of idx 2 ----
        tick(17);                                      // t=211 idx2 cnt3
        check("pre_rst_en",  32'(digit_en), 32'h4);
        check("pre_rst_seg", 32'(segments), 32'h7D);
        rstn = 1'b0;
        #1;
        check("mid_rst_en",  32'(digit_en), 32'h0);
        check("mid_rst_seg", 32'(segments), 32'h0);
        tick(2);
        rstn = 1'b1;                                   // t=0
`ifdef DISPLAY_BLINK_EN
        blink_mask = 4'b0001;
`endif
        tick(2);                                       // t=2
        check("rs_en0",   32'(digit_en), 32'h1);
        check("rs_seg0",  32'(segments), 32'h3F);
        tick(8);                                       // t=10
        check("rs_en1",   32'(digit_en), 32'h2);
        check("rs_seg1",  32'(segments), 32'h3F);
        lz_en = 1'b1;
        tick(1);                                       // t=11
        check("rs_lz1",   32'(segments), 32'h0);
        lz_en = 1'b0;

`ifdef DISPLAY_BLINK_EN
        // ---- blink: digit 0 on for t 0..63, off 64..127, on again ----
        tick(23);                                      // t=34
        check("bl_on0",   32'(segments), 32'h3F);
        tick(32);                                      // t=66
        check("bl_off_en", 32'(digit_en), 32'h1);
        check("bl_off0",  32'(segments), 32'h0);
        tick(8);                                       // t=74
        check("bl_dig1",  32'(segments), 32'h3F);
        tick(56);                                      // t=130
        check("bl_on0b",  32'(segments), 32'h3F);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
